// File: rtl/snowflake_pixel_streamer_pkg.sv
// Shared constants, colour codes and FSM encoding
// for the snowflake pixel streamer.
package snowflake_pixel_streamer_pkg;

    localparam logic signed [17:0] ONE = 18'sh10000;

    localparam logic [7:0] COL_FROZEN = 8'hFF;
    localparam logic [7:0] COL_EDGE   = 8'h1C;
    localparam logic [7:0] COL_NEG    = 8'h00;
    localparam logic [7:0] COL_SAT    = 8'h03;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WAIT,
        S_CAPTURE,
        S_EMIT,
        S_DONE
    } state_t;

endpackage

// File: rtl/snowflake_pixel_streamer_if.sv
// Pixel write handshake between the streamer
// (master) and the frame-buffer writer (slave).
interface snowflake_pixel_streamer_if;

    logic       pix_valid;
    logic       pix_ready;
    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic [7:0] pix_color;

    modport master (
        output pix_valid,
        output pix_x,
        output pix_y,
        output pix_color,
        input  pix_ready
    );

    modport slave (
        input  pix_valid,
        input  pix_x,
        input  pix_y,
        input  pix_color,
        output pix_ready
    );

endinterface

// File: rtl/cell_color_map.sv
// Maps one cell's (u, v) 2.16 values to an RGB332
// colour: frozen, receptive boundary, or u+v shade.
module cell_color_map (
    input  logic signed [17:0] i_u,
    input  logic signed [17:0] i_v,
    output logic        [7:0]  o_color
);
    import snowflake_pixel_streamer_pkg::*;

    logic signed [17:0] w_sum;

    // Priority colour decode; frozen beats boundary beats shade
    always_comb begin
        w_sum   = i_u + i_v;
        o_color = {6'b0, w_sum[15:14]};
        if (i_v >= ONE) begin
            o_color = COL_FROZEN;
        end else if (i_v > 18'sd0) begin
            o_color = COL_EDGE;
        end else if (w_sum < 18'sd0) begin
            o_color = COL_NEG;
        end else if (w_sum >= ONE) begin
            o_color = COL_SAT;
        end
    end

endmodule

// File: rtl/snowflake_pixel_streamer.sv
// Walks the u/v memories column by column and
// streams one coloured pixel per cell to the sink.
module snowflake_pixel_streamer #(
    parameter int NUM_ROWS = 11,
    parameter int NUM_COLS = 1,
    parameter int X_ORIGIN = 320,
    parameter int Y_ORIGIN = 240
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_start,
    output logic                       o_busy,
    output logic                       o_done,
    output logic               [18:0]  o_rd_addr,
    input  logic signed        [17:0]  i_rd_u_data,
    input  logic signed        [17:0]  i_rd_v_data,
    snowflake_pixel_streamer_if.master pix_if,
    output logic               [15:0]  o_frame_count
);
    import snowflake_pixel_streamer_pkg::*;

    state_t      r_state;
    state_t      w_next;
    logic [9:0]  r_row;
    logic [9:0]  r_col;
    logic [18:0] r_rd_addr;
    logic        r_pix_valid;
    logic [9:0]  r_pix_x;
    logic [9:0]  r_pix_y;
    logic [7:0]  r_pix_color;
    logic [15:0] r_frame_count;
    logic [7:0]  w_color;
    logic        w_hs;
    logic        w_last_row;
    logic        w_last_col;

    assign w_hs       = r_pix_valid && pix_if.pix_ready;
    assign w_last_row = (r_row == 10'(NUM_ROWS - 1));
    assign w_last_col = (r_col == 10'(NUM_COLS - 1));

    cell_color_map u_color (
        .i_u     (i_rd_u_data),
        .i_v     (i_rd_v_data),
        .o_color (w_color)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state: one address, one wait, one capture, then emit
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:    if (i_start) w_next = S_ADDR;
            S_ADDR:    w_next = S_WAIT;
            S_WAIT:    w_next = S_CAPTURE;
            S_CAPTURE: w_next = S_EMIT;
            S_EMIT: begin
                if (w_hs) begin
                    if (w_last_row && w_last_col) w_next = S_DONE;
                    else                          w_next = S_ADDR;
                end
            end
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Cell counters, read address, pixel registers, frame count
    always_ff @(posedge clk) begin
        if (reset) begin
            r_row         <= '0;
            r_col         <= '0;
            r_rd_addr     <= '0;
            r_pix_valid   <= 1'b0;
            r_pix_x       <= '0;
            r_pix_y       <= '0;
            r_pix_color   <= '0;
            r_frame_count <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_row <= '0;
                        r_col <= '0;
                    end
                end
                S_ADDR: begin
                    r_rd_addr <= 19'(r_col) * 19'(NUM_ROWS)
                               + 19'(r_row);
                end
                S_CAPTURE: begin
                    r_pix_color <= w_color;
                    r_pix_x     <= 10'(X_ORIGIN) + r_col;
                    r_pix_y     <= 10'(Y_ORIGIN) - r_row;
                    r_pix_valid <= 1'b1;
                end
                S_EMIT: begin
                    if (w_hs) begin
                        r_pix_valid <= 1'b0;
                        if (w_last_row) begin
                            r_row <= '0;
                            r_col <= r_col + 10'd1;
                        end else begin
                            r_row <= r_row + 10'd1;
                        end
                    end
                end
                S_DONE: begin
                    r_frame_count <= r_frame_count + 16'd1;
                end
                default: ;
            endcase
        end
    end

    assign o_busy           = (r_state != S_IDLE);
    assign o_done           = (r_state == S_DONE);
    assign o_rd_addr        = r_rd_addr;
    assign o_frame_count    = r_frame_count;
    assign pix_if.pix_valid = r_pix_valid;
    assign pix_if.pix_x     = r_pix_x;
    assign pix_if.pix_y     = r_pix_y;
    assign pix_if.pix_color = r_pix_color;

endmodule

// File: tb/tb_snowflake_pixel_streamer.sv
// Directed bench for snowflake_pixel_streamer:
// default 11x1 instance plus a 3x2 instance.
module tb_snowflake_pixel_streamer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset;
    logic               start_a, start_b;
    logic               busy_a, done_a, busy_b, done_b;
    logic        [18:0] addr_a, addr_b;
    logic signed [17:0] u_a, v_a, u_b, v_b;
    logic        [15:0] fc_a, fc_b;

    snowflake_pixel_streamer_if if_a ();
    snowflake_pixel_streamer_if if_b ();

    snowflake_pixel_streamer dut_a (
        .clk           (clk),
        .reset         (reset),
        .i_start       (start_a),
        .o_busy        (busy_a),
        .o_done        (done_a),
        .o_rd_addr     (addr_a),
        .i_rd_u_data   (u_a),
        .i_rd_v_data   (v_a),
        .pix_if        (if_a),
        .o_frame_count (fc_a)
    );

    snowflake_pixel_streamer #(
        .NUM_ROWS (3),
        .NUM_COLS (2)
    ) dut_b (
        .clk           (clk),
        .reset         (reset),
        .i_start       (start_b),
        .o_busy        (busy_b),
        .o_done        (done_b),
        .o_rd_addr     (addr_b),
        .i_rd_u_data   (u_b),
        .i_rd_v_data   (v_b),
        .pix_if        (if_b),
        .o_frame_count (fc_b)
    );

    // Registered-read memory models, one cycle latency
    logic signed [17:0] mu_a [16];
    logic signed [17:0] mv_a [16];
    logic signed [17:0] mu_b [8];
    logic signed [17:0] mv_b [8];

    always @(posedge clk) begin
        u_a <= mu_a[addr_a[3:0]];
        v_a <= mv_a[addr_a[3:0]];
        u_b <= mu_b[addr_b[2:0]];
        v_b <= mv_b[addr_b[2:0]];
    end

    int total = 0;
    int bad   = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor A: handshakes, done pulses, stall stability
    int          hs_a = 0, done_a_cnt = 0, stall_cnt = 0;
    logic [9:0]  qx[$], qy[$];
    logic [7:0]  qc[$];
    int          qt[$];
    logic        stall = 1'b0;
    logic [9:0]  sx, sy;
    logic [7:0]  sc;
    logic [18:0] sa;

    always @(negedge clk) begin
        if (reset) begin
            stall = 1'b0;
        end else begin
            if (stall) begin
                check("hold_v", if_a.pix_valid, 1);
                check("hold_x", if_a.pix_x, sx);
                check("hold_y", if_a.pix_y, sy);
                check("hold_c", if_a.pix_color, sc);
                check("hold_a", addr_a, sa);
            end
            stall = if_a.pix_valid && !if_a.pix_ready;
            if (stall) stall_cnt++;
            sx = if_a.pix_x;
            sy = if_a.pix_y;
            sc = if_a.pix_color;
            sa = addr_a;
            if (if_a.pix_valid && if_a.pix_ready) begin
                hs_a++;
                qx.push_back(if_a.pix_x);
                qy.push_back(if_a.pix_y);
                qc.push_back(if_a.pix_color);
                qt.push_back(cyc);
            end
            if (done_a) done_a_cnt++;
        end
    end

    // Monitor B: addresses and coordinates per handshake
    int          hs_b = 0, done_b_cnt = 0;
    logic [18:0] qa_b[$];
    logic [9:0]  qx_b[$], qy_b[$];

    always @(negedge clk) begin
        if (!reset) begin
            if (if_b.pix_valid && if_b.pix_ready) begin
                hs_b++;
                qa_b.push_back(addr_b);
                qx_b.push_back(if_b.pix_x);
                qy_b.push_back(if_b.pix_y);
            end
            if (done_b) done_b_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_a();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
    endtask

    task automatic clear_a();
        hs_a = 0;
        done_a_cnt = 0;
        stall_cnt = 0;
        qx.delete();
        qy.delete();
        qc.delete();
        qt.delete();
    endtask

    task automatic wait_done_a(string tag);
        int n = 0;
        while (done_a_cnt < 1 && n < 400) begin
            tick();
            n++;
        end
        check({tag, "_done"}, done_a_cnt, 1);
    endtask

    task automatic wait_hs_a(int k);
        int n = 0;
        while (hs_a < k && n < 200) begin
            tick();
            n++;
        end
        check("hs_reach", hs_a >= k, 1);
    endtask

    task automatic wait_valid_a();
        int n = 0;
        while (!if_a.pix_valid && n < 50) begin
            tick();
            n++;
        end
        check("valid_seen", if_a.pix_valid, 1);
    endtask

    task automatic check_frame(string nm, input logic [7:0] ec [11]);
        check({nm, "_hs"}, hs_a, 11);
        for (int i = 0; i < 11; i++) begin
            if (i < qx.size()) begin
                check($sformatf("%s_x%0d", nm, i), qx[i], 320);
                check($sformatf("%s_y%0d", nm, i), qy[i], 240 - i);
                check($sformatf("%s_c%0d", nm, i), qc[i], ec[i]);
            end
        end
    endtask

    task automatic load_init();
        for (int i = 0; i < 16; i++) begin
            mu_a[i] = 18'sh04000;
            mv_a[i] = 18'sh00000;
        end
        mu_a[2] = 18'sh0;
        mu_a[3] = 18'sh0;
        mu_a[4] = 18'sh0;
        mv_a[2] = 18'sh06000;
        mv_a[3] = 18'sh12000;
        mv_a[4] = 18'sh06000;
    endtask

    logic [7:0] ec_init [11];
    logic [7:0] ec_bnd  [11];

    initial begin
        ec_init = '{8'h01, 8'h01, 8'h1C, 8'hFF, 8'h1C, 8'h01,
                    8'h01, 8'h01, 8'h01, 8'h01, 8'h01};
        ec_bnd  = '{8'h00, 8'h03, 8'h03, 8'hFF, 8'h1C, 8'h03,
                    8'hFF, 8'h1C, 8'h02, 8'h00, 8'h02};
        load_init();
        for (int i = 0; i < 8; i++) begin
            mu_b[i] = 18'sh0;
            mv_b[i] = 18'sh0;
        end
        reset = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        if_a.pix_ready = 1'b1;
        if_b.pix_ready = 1'b1;
        repeat (3) tick();

        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_valid", if_a.pix_valid, 0);
        check("rst_x", if_a.pix_x, 0);
        check("rst_y", if_a.pix_y, 0);
        check("rst_col", if_a.pix_color, 0);
        check("rst_addr", addr_a, 0);
        check("rst_fc", fc_a, 0);
        reset = 1'b0;
        tick();

        // Frame 1: solver initial state, ready high
        clear_a();
        pulse_a();
        check("busy_run", busy_a, 1);
        wait_done_a("f1");
        check_frame("f1", ec_init);
        check("f1_fc", fc_a, 1);
        check("f1_busy", busy_a, 0);
        if (qt.size() > 2) begin
            check("tput01", qt[1] - qt[0], 4);
            check("tput12", qt[2] - qt[1], 4);
        end

        // Frame 2: sink stalls for 5 cycles on pixel 4
        clear_a();
        pulse_a();
        wait_hs_a(4);
        if_a.pix_ready = 1'b0;
        wait_valid_a();
        repeat (5) tick();
        if_a.pix_ready = 1'b1;
        wait_done_a("f2");
        check("f2_stall", stall_cnt, 5);
        check_frame("f2", ec_init);
        check("f2_fc", fc_a, 2);

        // Frame 3: extra start pulses while busy are ignored
        clear_a();
        pulse_a();
        repeat (3) tick();
        pulse_a();
        repeat (10) tick();
        pulse_a();
        wait_done_a("f3");
        repeat (30) tick();
        check("f3_ndone", done_a_cnt, 1);
        check("f3_idle", busy_a, 0);
        check("f3_hs", hs_a, 11);
        check("f3_fc", fc_a, 3);

        // Reset while pixel 6 is being offered
        clear_a();
        pulse_a();
        wait_hs_a(6);
        if_a.pix_ready = 1'b0;
        wait_valid_a();
        reset = 1'b1;
        tick();
        check("mr_valid", if_a.pix_valid, 0);
        check("mr_busy", busy_a, 0);
        check("mr_fc", fc_a, 0);
        reset = 1'b0;
        if_a.pix_ready = 1'b1;
        repeat (5) tick();
        check("mr_nodone", done_a_cnt, 0);
        check("mr_hs", hs_a, 6);
        clear_a();
        pulse_a();
        wait_done_a("f4");
        check_frame("f4", ec_init);
        check("f4_fc", fc_a, 1);

        // Boundary colour cells
        mu_a[0] = 18'h3FF00; mv_a[0] = 18'sh0;
        mu_a[1] = 18'sh10000; mv_a[1] = 18'sh0;
        mu_a[2] = 18'sh0C000; mv_a[2] = 18'sh0;
        mu_a[5] = 18'sh0FFFF; mv_a[5] = 18'sh0;
        mu_a[6] = 18'sh0;     mv_a[6] = 18'sh10000;
        mu_a[7] = 18'sh0;     mv_a[7] = 18'sh00001;
        mu_a[8] = 18'sh0BFFF; mv_a[8] = 18'sh0;
        mu_a[9] = 18'sh0;     mv_a[9] = 18'sh0;
        mu_a[10] = 18'sh08100; mv_a[10] = 18'h3FF00;
        clear_a();
        pulse_a();
        wait_done_a("f5");
        check_frame("f5", ec_bnd);
        check("f5_fc", fc_a, 2);

        // 3x2 instance: address order and x per column
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        begin
            int n = 0;
            while (done_b_cnt < 1 && n < 200) begin
                tick();
                n++;
            end
        end
        check("b_done", done_b_cnt, 1);
        check("b_hs", hs_b, 6);
        for (int i = 0; i < 6; i++) begin
            if (i < qa_b.size()) begin
                check($sformatf("b_addr%0d", i), qa_b[i], i);
                check($sformatf("b_x%0d", i), qx_b[i], 320 + i / 3);
                check($sformatf("b_y%0d", i), qy_b[i], 240 - i % 3);
            end
        end
        check("b_fc", fc_b, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/snowflake_pixel_streamer.md
SNOWFLAKE_PIXEL_STREAMER -- requirements
Module: snowflake_pixel_streamer

Interface
REQ-001 The block SHALL have parameter NUM_ROWS, default 11, meaning cells per column.
REQ-002 The block SHALL have parameter NUM_COLS, default 1, meaning columns stored in the u/v memories.
REQ-003 The block SHALL have parameter X_ORIGIN, default 320, meaning the screen x of column 0.
REQ-004 The block SHALL have parameter Y_ORIGIN, default 240, meaning the screen y of row 0.
REQ-005 clk  in  1  clock; reset reset, synchronous, active-high; clock clk.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 start  in  1  one-cycle pulse meaning the solver iteration is complete and the frame may be streamed.
REQ-008 busy  out  1  high from the accepted start until done.
REQ-009 done  out  1  one-cycle pulse after the last pixel handshake.
REQ-010 rd_addr  out  19  shared read address to the u_curr and v_next M10Ks.
REQ-011 rd_u_data  in  18  signed 2.16 u_curr read data.
REQ-012 rd_v_data  in  18  signed 2.16 v_next read data.
REQ-013 pix_valid  out  1  pixel write request.
REQ-014 pix_ready  in  1  the pixel sink accepts the request.
REQ-015 pix_x  out  10  pixel x; pix_y  out  10  pixel y; pix_color  out  8  pixel colour in RGB332.
REQ-016 frame_count  out  16  count of completed frames.

Function
REQ-017 The FSM SHALL have states IDLE, ADDR, WAIT, CAPTURE, EMIT and DONE.
REQ-018 IDLE SHALL move to ADDR on start, with row=0 and col=0; start SHALL be ignored in every other state.
REQ-019 ADDR SHALL register rd_addr = col*NUM_ROWS + row and move to WAIT.
REQ-020 WAIT SHALL move to CAPTURE; the memory read latency is 1 clock after address registration.
REQ-021 CAPTURE SHALL latch rd_u_data and rd_v_data, compute colour and coordinates, assert pix_valid and move to EMIT.
REQ-022 EMIT SHALL hold pix_valid, pix_x, pix_y and pix_color stable until pix_valid&&pix_ready.
REQ-023 On a handshake in EMIT, the block SHALL deassert pix_valid and advance: row increments; at row==NUM_ROWS-1, row wraps to 0 and col increments.
REQ-024 If the handshake is on the last cell (row==NUM_ROWS-1, col==NUM_COLS-1), the block SHALL go to DONE; otherwise it SHALL go to ADDR.
REQ-025 DONE SHALL pulse done for one cycle, increment frame_count (modulo 2^16, wraps) and return to IDLE.
REQ-026 pix_x SHALL equal X_ORIGIN + col.
REQ-027 pix_y SHALL equal Y_ORIGIN - row, so the column grows upward.
REQ-028 Colour priority 1: v >= 0x10000 (frozen) -> 8'hFF.
REQ-029 Colour priority 2: 0 < v < 0x10000 (receptive boundary) -> 8'h1C.
REQ-030 Colour priority 3: otherwise, s = u + v (18-bit signed, wrap not possible for legal inputs); s<0 -> 8'h00, s>=0x10000 -> 8'h03, else {6'b0, s[15:14]}.
REQ-031 Minimum throughput SHALL be 4 clocks per pixel when pix_ready is held high.
REQ-032 busy SHALL be 0 only in IDLE.

Reset
REQ-033 On reset, the block SHALL enter IDLE, and all outputs SHALL clear to 0 (rd_addr, pix_*, busy, done, frame_count) along with row and col.
REQ-034 Reset mid-frame SHALL abort immediately: pix_valid low next cycle, no done pulse, frame_count unchanged from 0.

Structure
REQ-035 The fixed-point ONE constant (18'h10000), the colour constants and the FSM state encoding SHALL live in the shared snowflake package.
REQ-036 The colour mapping SHALL be one combinational sub-module, cell_color_map (u, v -> 8-bit colour); the FSM and counters SHALL stay in the top.

Verification
REQ-037 Scenario: memory loaded per the solver's initial state (addr 3 v=0x12000, addr 2,4 v=0x06000, others u=0x04000, v=0) and ready always high -> 11 pixels, y 240..230; colours FF at y=237, 1C at y=238/236, 01 elsewhere; done 1 cycle; frame_count=1.
REQ-038 Scenario: pix_ready low for 5 cycles on pixel 4 -> pix_valid/x/y/colour stable throughout; no address advance; exactly 11 handshakes.
REQ-039 Scenario: start pulsed again while busy -> ignored; one done; frame_count increments by exactly 1.
REQ-040 Scenario: reset asserted at pixel 6 -> pix_valid=0 and busy=0 next cycle; no done; a subsequent start streams a full 11-pixel frame from row 0.
REQ-041 Scenario: boundary colours u=-0x00100, v=0 -> 00; u=0x10000, v=0 -> 03; u=0x0C000, v=0 -> 03 (s[15:14]=11).
REQ-042 Scenario: NUM_COLS=2, NUM_ROWS=3 -> addresses 0..5 in order, pix_x 320,320,320,321,321,321.
